// File: rtl/scc_pkg.sv
// scc_pkg: shared types and defaults for the scc core memory port.
package scc_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt: saturating count of data grants won while fetch waits.
module arb_starve_cnt
    import scc_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_en,
    input  logic inc,
    input  logic clr,
    output logic limit
);

    localparam logic [3:0] MAX = 4'(STARVE_MAX);

    logic [3:0] streak;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            streak <= '0;
        else if (clk_en)
            streak <= clr ? '0 : (inc && streak != MAX) ? streak + 4'd1 : streak;
    end

    assign limit = streak == MAX;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store,
// data first, with a starvation bound on fetch and one-cycle read routing.
module mem_port_arbiter
    import scc_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    owner_t owner;
    logic   limit;
    logic   live;

    // Nothing may be granted while frozen or held in reset.
    assign live   = clk_en & rst;
    assign if_gnt = live & if_req & (~d_req | limit);
    assign d_gnt  = live & d_req & ~if_gnt;

    assign mem_addr  = if_gnt ? if_addr : d_gnt ? d_addr : '0;
    assign mem_wdata = (if_gnt | d_gnt) ? d_wdata : '0;
    assign mem_we    = d_gnt & d_we;
    assign mem_re    = if_gnt | (d_gnt & ~d_we);
    assign stall     = ~rst | (if_req & ~if_gnt) | (d_req & ~d_gnt);

    assign if_rvalid = owner == OWN_IF;
    assign d_rvalid  = owner == OWN_D;
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            owner <= OWN_NONE;
        else if (clk_en)
            owner <= if_gnt ? OWN_IF : (d_gnt & ~d_we) ? OWN_D : OWN_NONE;
    end

    arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .inc    (d_gnt & if_req),
        .clr    (if_gnt | ~if_req),
        .limit  (limit)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random stimulus against a rule-level model.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SM = 4;

    logic          clk = 0, rst = 0, clk_en = 1;
    logic          if_req = 0, d_req = 0, d_we = 0;
    logic [AW-1:0] if_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
    logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_we, mem_re, stall;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata), .stall(stall)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int m_streak = 0;
    int m_owner = 0;
    logic live, e_if, e_d;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: how long fetch has been passed over, and who owns the read in flight.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_streak <= 0;
            m_owner  <= 0;
        end else if (clk_en) begin
            if (if_req && (!d_req || m_streak == SM)) begin
                m_owner  <= 1;
                m_streak <= 0;
            end else if (d_req) begin
                m_owner  <= d_we ? 0 : 2;
                m_streak <= !if_req ? 0 : (m_streak < SM ? m_streak + 1 : m_streak);
            end else begin
                m_owner  <= 0;
                m_streak <= 0;
            end
        end
    end

    always @(negedge clk) begin
        live = rst && clk_en;
        e_if = live && if_req && (!d_req || m_streak == SM);
        e_d  = live && d_req && !e_if;
        chk("if_gnt", if_gnt, e_if);
        chk("d_gnt", d_gnt, e_d);
        chk("mem_we", mem_we, e_d && d_we);
        chk("mem_re", mem_re, e_if || (e_d && !d_we));
        chk("mem_addr", mem_addr, e_if ? if_addr : e_d ? d_addr : '0);
        if (e_d) chk("mem_wdata", mem_wdata, d_wdata);
        if (!e_if && !e_d) chk("mem_wdata_idle", mem_wdata, 0);
        chk("stall", stall, !rst || (if_req && !e_if) || (d_req && !e_d));
        chk("if_rvalid", if_rvalid, m_owner == 1);
        chk("d_rvalid", d_rvalid, m_owner == 2);
        if (m_owner == 1) chk("if_rdata", if_rdata, mem_rdata);
        if (m_owner == 2) chk("d_rdata", d_rdata, mem_rdata);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic peek();
        #3;
    endtask

    initial begin
        logic [9:0] pat;
        pat = 10'b1000010000;
        step();
        peek();
        chk("rst_stall", stall, 1);
        chk("rst_if_rvalid", if_rvalid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        step();
        rst = 1;

        // lone fetch
        if_req = 1; if_addr = 32'h40;
        peek();
        chk("lone_if_gnt", if_gnt, 1);
        chk("lone_mem_re", mem_re, 1);
        chk("lone_mem_addr", mem_addr, 32'h40);
        step();
        if_req = 0; mem_rdata = 32'hDEADBEEF;
        peek();
        chk("lone_if_rvalid", if_rvalid, 1);
        chk("lone_if_rdata", if_rdata, 32'hDEADBEEF);
        chk("lone_d_rvalid", d_rvalid, 0);

        // store against fetch
        step();
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'h5; if_req = 1; if_addr = 32'h44;
        peek();
        chk("st_d_gnt", d_gnt, 1);
        chk("st_mem_we", mem_we, 1);
        chk("st_stall", stall, 1);
        chk("st_if_gnt", if_gnt, 0);
        step();
        d_req = 0; d_we = 0;
        peek();
        chk("st_then_if_gnt", if_gnt, 1);
        chk("st_no_d_rvalid", d_rvalid, 0);
        step();
        if_req = 0;

        // starvation bound
        step();
        if_req = 1; d_req = 1; d_addr = 32'h200; if_addr = 32'h80;
        for (int i = 0; i < 10; i++) begin
            peek();
            chk("starve_if", if_gnt, pat[i]);
            chk("starve_d", d_gnt, !pat[i]);
            step();
        end
        if_req = 0; d_req = 0;

        // pipelined reads alternating owners
        step();
        if_req = 1; if_addr = 32'h300;
        step();
        if_req = 0; d_req = 1; d_addr = 32'h400; mem_rdata = 32'h11111111;
        peek();
        chk("pipe_if_rv", if_rvalid, 1);
        chk("pipe_d_gnt", d_gnt, 1);
        step();
        d_req = 0; if_req = 1; if_addr = 32'h304; mem_rdata = 32'h22222222;
        peek();
        chk("pipe_d_rv", d_rvalid, 1);
        chk("pipe_d_rdata", d_rdata, 32'h22222222);
        chk("pipe_if_gnt", if_gnt, 1);
        step();
        if_req = 0; mem_rdata = 32'h33333333;
        peek();
        chk("pipe_if_rv2", if_rvalid, 1);

        // freeze with a load response pending
        step();
        d_req = 1; d_addr = 32'h500;
        step();
        clk_en = 0; if_req = 1;
        for (int i = 0; i < 3; i++) begin
            peek();
            chk("frz_d_rvalid", d_rvalid, 1);
            chk("frz_d_gnt", d_gnt, 0);
            chk("frz_mem_re", mem_re, 0);
            chk("frz_stall", stall, 1);
            step();
        end
        clk_en = 1; if_req = 0; d_req = 0;
        step();

        // reset in the middle of a streak with a load in flight
        if_req = 1; d_req = 1;
        step(); step(); step();
        chk("pre_rst_d_rvalid", d_rvalid, 1);
        #1 rst = 0;
        #1;
        chk("rst_d_rvalid", d_rvalid, 0);
        chk("rst_if_rvalid2", if_rvalid, 0);
        step();
        rst = 1; d_req = 0;
        peek();
        chk("post_rst_if_gnt", if_gnt, 1);
        step();
        d_req = 1;
        for (int i = 0; i < 5; i++) begin
            peek();
            chk("post_rst_pat", if_gnt, i == 4);
            step();
        end

        // random traffic, model-checked every cycle
        for (int i = 0; i < 60; i++) begin
            clk_en = $urandom_range(0, 3) != 0;
            if_req = 1'($urandom);
            d_req = 1'($urandom);
            d_we = 1'($urandom);
            if_addr = $urandom;
            d_addr = $urandom;
            d_wdata = $urandom;
            mem_rdata = $urandom;
            step();
        end
        if_req = 0; d_req = 0; clk_en = 1;
        step(); step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified instruction/data memory port between the instruction fetch path and the execute-stage load/store path of the scc core. The port issues one access per enabled cycle. Data accesses have priority; a starvation counter bounds how long fetch can be blocked. Read responses are routed back to the owning requester one cycle later. The core stalls on `stall` whenever a pending request is not granted.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `STARVE_MAX`, 4, consecutive data grants tolerated while fetch waits (range 1..15)

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  reset, asynchronous, active-low
- `clk_en`  in  1  clock enable; low freezes all state
- `if_req`  in  1  fetch read request; held until granted
- `if_addr`  in  ADDR_W  fetch address
- `if_gnt`  out  1  fetch granted this cycle
- `if_rvalid`  out  1  fetch read data valid
- `if_rdata`  out  DATA_W  fetch read data
- `d_req`  in  1  data request; held until granted
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_gnt`  out  1  data granted this cycle
- `d_rvalid`  out  1  load data valid
- `d_rdata`  out  DATA_W  load data
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_we`  out  1  memory write strobe
- `mem_re`  out  1  memory read strobe
- `mem_rdata`  in  DATA_W  memory read data; valid one enabled cycle after `mem_re`
- `stall`  out  1  a request is pending but not granted

## Operation
- Grant logic is combinational, in the same cycle as the request. At most one of `if_gnt`/`d_gnt` is high.
- Priority:
  - Data wins by default.
  - Fetch wins when both requests are high and `streak == STARVE_MAX`.
  - A lone request is always granted.
- `streak` counter (4 bits):
  - Increments on a data grant while `if_req` is high.
  - Clears on a fetch grant, or on any enabled cycle with `if_req` low.
  - Saturates at STARVE_MAX.
- Memory command for the granted requester:
  - `mem_addr` = granted address.
  - `mem_we = d_gnt & d_we`.
  - `mem_re = if_gnt | (d_gnt & ~d_we)`.
  - `mem_wdata = d_wdata`.
- No grant: `mem_we = mem_re = 0`; `mem_addr`/`mem_wdata` are don't-care and are driven 0.
- `owner` register (OWN_NONE / OWN_IF / OWN_D):
  - On each enabled edge, loads the owner of the read issued that cycle, or OWN_NONE.
  - Stores set OWN_NONE.
- Response routing:
  - `if_rvalid = (owner == OWN_IF)`; `d_rvalid = (owner == OWN_D)`.
  - `if_rdata` and `d_rdata` both equal `mem_rdata`; each is qualified only by its own rvalid.
- `stall = (if_req & ~if_gnt) | (d_req & ~d_gnt)`.
- `clk_en` low:
  - Grants, `mem_we` and `mem_re` forced 0.
  - `owner` and `streak` hold, so rvalid is held.
  - `stall` = `if_req | d_req`.
- Reset asserted, asynchronously:
  - `owner` = OWN_NONE and `streak` = 0.
  - All gnt, rvalid, `mem_we` and `mem_re` outputs are 0; `mem_addr` and `mem_wdata` are 0.
  - `stall` = 1.
  - An in-flight read response is dropped.

## Timing
- Grant latency: 0 cycles.
- Read data latency: 1 enabled cycle after grant.
- Store completes at the grant edge; no response is generated.
- Back-to-back grants every cycle are allowed.
  - A new read may be issued in the same cycle that the previous read's rvalid is high.
- Worst-case fetch wait with data continuously requesting: STARVE_MAX cycles, then one fetch grant.
- Simultaneous events:
  - Both requests arriving in the first cycle after reset: data wins, `streak` becomes 1.
  - `if_req` dropping while `streak == STARVE_MAX`: `streak` clears.

## Structure
- Shared package `scc_pkg`:
  - `owner_t` enum (OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_D = 2'd2).
  - Default `STARVE_MAX` constant.
- One sub-module, `arb_starve_cnt`, is natural:
  - Holds the saturating streak counter.
  - Inputs: `inc`, `clr`, `clk_en`.
  - Output: `limit` (high when `streak == STARVE_MAX`).
- Grant, mux and owner logic live in the top module.

## Test plan
- Lone fetch: `if_req=1`, `if_addr=0x40`, `mem_rdata=0xDEADBEEF` next cycle -> same cycle `if_gnt=1`, `mem_re=1`, `mem_addr=0x40`; next cycle `if_rvalid=1`, `if_rdata=0xDEADBEEF`, `d_rvalid=0`.
- Store vs fetch conflict: `d_req=1`, `d_we=1`, `d_addr=0x100`, `d_wdata=0x5`, `if_req=1` -> `d_gnt=1`, `mem_we=1`, `stall=1`, `if_gnt=0`; next cycle `if_gnt=1` and no `d_rvalid`.
- Starvation, `STARVE_MAX=4`: `d_req` and `if_req` held high for 10 cycles -> grant pattern D,D,D,D,IF,D,D,D,D,IF.
- Pipelined reads: alternating fetch and load grants on consecutive cycles -> each rvalid arrives exactly one cycle after its grant and is routed to the correct requester.
- `clk_en` low for 3 cycles with `owner = OWN_D` -> `d_rvalid` held high, no grants, `mem_re=0`, `stall=1` while requesting.
- Reset pulsed mid-read -> `if_rvalid` and `d_rvalid` go to 0 immediately and `streak=0`; after release, a lone `if_req` is granted in the same cycle.
